// File: rtl/dkong3_snd_mixer.sv
// N-channel signed sample mixer: snapshot on strobe, one gained channel accumulated per clock,
// then arithmetic scaling and saturation to the output width.
module dkong3_snd_mixer #(
  parameter int NCH   = 2,
  parameter int SW    = 16,
  parameter int GW    = 4,
  parameter int GFRAC = 3
) (
  input  logic              I_SUBCLK,
  input  logic              I_SUB_RESETn,
  input  logic              I_SAMPLE_CE,
  input  logic [NCH*SW-1:0] I_SAMPLES,
  input  logic [NCH*GW-1:0] I_GAINS,
  input  logic [NCH-1:0]    I_MUTE,
  output logic [SW-1:0]     O_SAMPLE,
  output logic              O_VALID,
  output logic              O_CLIP,
  output logic              O_BUSY,
  output logic              O_DROP,
  output logic [1:0]        O_DBG_STATE
);

  localparam int AW = SW + GW + $clog2(NCH) + 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NCH*SW-1:0]    samp_q, samp_d;
  logic [NCH*GW-1:0]    gain_q, gain_d;
  logic [NCH-1:0]       mute_q, mute_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 clip_q, clip_d;
  logic                 drop_q, drop_d;

  logic [SW-1:0]        cur_samp;
  logic [GW-1:0]        cur_gain;
  logic signed [AW-1:0] samp_ext, gain_ext, prod, shifted;
  logic [AW-SW:0]       hi;
  logic                 pos_ovf, neg_ovf, snap;

  always_comb begin
    cur_samp = samp_q[int'(idx_q)*SW +: SW];
    cur_gain = gain_q[int'(idx_q)*GW +: GW];
    samp_ext = AW'($signed(cur_samp));
    gain_ext = AW'({1'b0, cur_gain});
    prod     = samp_ext * gain_ext;
    // Floor scaling; the bits above the output sign bit must all agree or the result clips.
    shifted  = acc_q >>> GFRAC;
    hi       = shifted[AW-1:SW-1];
    pos_ovf  = !shifted[AW-1] && (|hi);
    neg_ovf  = shifted[AW-1] && !(&hi);
    snap     = I_SAMPLE_CE && ((state_q == S_IDLE) || (state_q == S_OUT));

    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    samp_d   = samp_q;
    gain_d   = gain_q;
    mute_d   = mute_q;
    sample_d = sample_q;
    clip_d   = clip_q;
    valid_d  = 1'b0;
    drop_d   = 1'b0;

    case (state_q)
      S_ACC: begin
        acc_d  = acc_q + (mute_q[idx_q] ? '0 : prod);
        idx_d  = idx_q + IW'(1);
        drop_d = I_SAMPLE_CE;
        if (idx_q == IW'(NCH - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        valid_d = 1'b1;
        clip_d  = pos_ovf || neg_ovf;
        if (pos_ovf)      sample_d = {1'b0, {(SW-1){1'b1}}};
        else if (neg_ovf) sample_d = {1'b1, {(SW-1){1'b0}}};
        else              sample_d = shifted[SW-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (snap) begin
      samp_d  = I_SAMPLES;
      gain_d  = I_GAINS;
      mute_d  = I_MUTE;
      acc_d   = '0;
      idx_d   = '0;
      state_d = S_ACC;
    end
  end

  always_ff @(posedge I_SUBCLK or negedge I_SUB_RESETn) begin
    if (!I_SUB_RESETn) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      samp_q   <= '0;
      gain_q   <= '0;
      mute_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      samp_q   <= samp_d;
      gain_q   <= gain_d;
      mute_q   <= mute_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
      drop_q   <= drop_d;
    end
  end

  assign O_SAMPLE    = sample_q;
  assign O_VALID     = valid_q;
  assign O_CLIP      = clip_q;
  assign O_DROP      = drop_q;
  assign O_BUSY      = (state_q == S_ACC);
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_dkong3_snd_mixer.sv
// Directed bench for dkong3_snd_mixer (NCH=2): reference model feeds an expected queue,
// a monitor pops it on every O_VALID pulse.
module tb_dkong3_snd_mixer;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [31:0] samples;
  logic [7:0]  gains;
  logic [1:0]  mute;
  logic [15:0] o_sample;
  logic        o_valid, o_clip, o_busy, o_drop;
  logic [1:0]  o_dbg_state;

  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          vcyc_q[$];
  logic        prev_valid = 1'b0;

  dkong3_snd_mixer #(.NCH(2), .SW(16), .GW(4), .GFRAC(3)) dut (
    .I_SUBCLK    (clk),
    .I_SUB_RESETn(rst_n),
    .I_SAMPLE_CE (ce),
    .I_SAMPLES   (samples),
    .I_GAINS     (gains),
    .I_MUTE      (mute),
    .O_SAMPLE    (o_sample),
    .O_VALID     (o_valid),
    .O_CLIP      (o_clip),
    .O_BUSY      (o_busy),
    .O_DROP      (o_drop),
    .O_DBG_STATE (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: {clip, sample}
  function automatic logic [16:0] model(input logic [15:0] s0, input logic [15:0] s1,
                                        input logic [3:0] g0, input logic [3:0] g1,
                                        input logic [1:0] m);
    int sum;
    int q;
    sum = 0;
    if (!m[0]) sum += int'($signed(s0)) * int'(g0);
    if (!m[1]) sum += int'($signed(s1)) * int'(g1);
    q = sum >>> 3;
    if (q > 32767)       return {1'b1, 16'h7FFF};
    else if (q < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, q[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (o_valid) begin
      check("valid_single_pulse", 32'(prev_valid), 32'd0);
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("mix_result", {15'd0, o_clip, o_sample}, {15'd0, exp_q.pop_front()});
      vcyc_q.push_back(cycle);
    end
    prev_valid = o_valid;
  end

  // driver tasks
  task automatic drive(input logic [15:0] s0, input logic [15:0] s1,
                       input logic [3:0] g0, input logic [3:0] g1,
                       input logic [1:0] m, input logic strobe);
    samples = {s1, s0};
    gains   = {g1, g0};
    mute    = m;
    ce      = strobe;
    if (strobe) exp_q.push_back(model(s0, s1, g0, g1, m));
  endtask

  task automatic send(input logic [15:0] s0, input logic [15:0] s1,
                      input logic [3:0] g0, input logic [3:0] g1, input logic [1:0] m);
    drive(s0, s1, g0, g1, m, 1'b1);
    @(posedge clk); #1;
    drive($urandom_range(0, 65535), $urandom_range(0, 65535),
          $urandom_range(0, 15), $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(16'h0, 16'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_sample", 32'(o_sample), 32'h0);
    check("reset_flags", {28'd0, o_valid, o_clip, o_busy, o_drop}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unity mix with latency checks
    send(16'h1000, 16'h0800, 4'd8, 4'd8, 2'b00);
    check("busy_in_acc", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    check("busy_first_acc", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    check("not_busy_in_out", 32'(o_busy), 32'd0);
    check("no_valid_before_edge3", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_after_edge3", 32'(o_valid), 32'd1);
    check("unity_value", {15'd0, o_clip, o_sample}, 32'h1800);
    wait_drain("unity_drain");

    send(16'h7000, 16'h7000, 4'd8, 4'd8, 2'b00); wait_drain("sat_pos");
    check("sat_pos_value", {15'd0, o_clip, o_sample}, 32'h17FFF);
    send(16'h9000, 16'h9000, 4'd8, 4'd8, 2'b00); wait_drain("sat_neg");
    check("sat_neg_value", {15'd0, o_clip, o_sample}, 32'h18000);
    send(16'h1000, 16'h7000, 4'd4, 4'd8, 2'b10);  wait_drain("gain4");
    send(16'h1000, 16'h7000, 4'd15, 4'd15, 2'b10); wait_drain("gain15");
    check("gain15_value", {15'd0, o_clip, o_sample}, 32'h1E00);
    send(16'h1000, 16'h7000, 4'd0, 4'd8, 2'b10);  wait_drain("gain0");
    send(16'hFFFF, 16'h7000, 4'd4, 4'd8, 2'b10);  wait_drain("floor");
    check("floor_value", {15'd0, o_clip, o_sample}, 32'hFFFF);
    send(16'h4321, 16'hC000, 4'd9, 4'd13, 2'b00); wait_drain("mixed_signs");

    // strobe during ACC is dropped
    send(16'h0400, 16'h0200, 4'd8, 4'd8, 2'b00);
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    check("drop_pulse", 32'(o_drop), 32'd1);
    @(posedge clk); #1;
    check("drop_clears", 32'(o_drop), 32'd0);
    wait_drain("drop_result");

    // back-to-back strobes in OUT; inputs changed after each snapshot
    vcyc_q.delete();
    send(16'h0100, 16'h0200, 4'd8, 4'd8, 2'b00);
    drive(16'h3000, 16'hF000, 4'd12, 4'd5, 2'b00, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    drive(16'h3000, 16'hF000, 4'd12, 4'd5, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(16'h8000, 16'h8000, 4'd15, 4'd15, 2'b00, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    drive(16'h8000, 16'h8000, 4'd15, 4'd15, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(16'h1111, 16'h2222, 4'd3, 4'd3, 2'b00, 1'b0);
    wait_drain("b2b_drain");
    check("b2b_count", 32'(vcyc_q.size()), 32'd3);
    if (vcyc_q.size() == 3) begin
      check("b2b_gap1", 32'(vcyc_q[1] - vcyc_q[0]), 32'd3);
      check("b2b_gap2", 32'(vcyc_q[2] - vcyc_q[1]), 32'd3);
    end

    // reset during ACC aborts the mix
    send(16'h2000, 16'h2000, 4'd8, 4'd8, 2'b00);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_sample", 32'(o_sample), 32'h0);
    check("abort_flags", {28'd0, o_valid, o_clip, o_busy, o_drop}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_valid_sample", 32'(o_sample), 32'h0);
    send(16'h0123, 16'hFF00, 4'd8, 4'd2, 2'b00); wait_drain("post_reset_mix");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
